// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int unsigned DCACHE_DATA_WIDTH = 32;
    localparam int unsigned DCACHE_BE_W       = DCACHE_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        WDONE
    } dcache_state_e;

    function automatic logic [DCACHE_DATA_WIDTH-1:0] byte_merge(
        input logic [DCACHE_DATA_WIDTH-1:0] old_word,
        input logic [DCACHE_DATA_WIDTH-1:0] new_word,
        input logic [DCACHE_BE_W-1:0]       be
    );
        logic [DCACHE_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(DCACHE_BE_W); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read port, one byte-merging write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned SETS  = 64,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = DCACHE_DATA_WIDTH - 2 - IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic                         rd_valid,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [DCACHE_DATA_WIDTH-1:0] rd_data,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [DCACHE_DATA_WIDTH-1:0] wr_data,
    input  logic [DCACHE_BE_W-1:0]       wr_be
);

    logic [SETS-1:0]              valid_q;
    logic [TAG_W-1:0]             tag_q  [SETS];
    logic [DCACHE_DATA_WIDTH-1:0] data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are deliberately left unreset; valid gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= byte_merge(data_q[wr_idx], wr_data, wr_be);
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through no-write-allocate M-stage data cache.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DCACHE_DATA_WIDTH,
    parameter int unsigned SETS       = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MemReadM,
    input  logic                    MemWriteM,
    input  logic [DATA_WIDTH-1:0]   AddrM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    input  logic [DATA_WIDTH/8-1:0] ByteEnM,
    output logic [DATA_WIDTH-1:0]   DMRd,
    output logic                    StallM,
    output logic                    MemReq,
    output logic                    MemWe,
    output logic [DATA_WIDTH-1:0]   MemAddr,
    output logic [DATA_WIDTH-1:0]   MemWData,
    output logic [DATA_WIDTH/8-1:0] MemBe,
    input  logic [DATA_WIDTH-1:0]   MemRData,
    input  logic                    MemAck
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]             HitCount,
    output logic [31:0]             MissCount
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = DATA_WIDTH - 2 - IDX_W;

    dcache_state_e           state_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [DATA_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH/8-1:0] mem_be_q;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  hit;
    logic                  fill_en;
    logic                  store_en;
    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH/8-1:0] arr_be;

    assign idx = AddrM[2 +: IDX_W];
    assign tag = AddrM[DATA_WIDTH-1 -: TAG_W];
    assign hit = line_valid && (line_tag == tag);

    assign fill_en   = (state_q == FETCH) && MemAck;
    assign store_en  = (state_q == WRITE) && MemAck && hit;
    assign arr_we    = (fill_en || store_en) && !rst;
    assign arr_wdata = fill_en ? MemRData : mem_wdata_q;
    assign arr_be    = fill_en ? '1 : mem_be_q;

    dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (arr_wdata),
        .wr_be    (arr_be)
    );

    // Request fields are captured on leaving IDLE so they stay stable until MemAck.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemWriteM) begin
                        state_q     <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {AddrM[DATA_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= WriteDataM;
                        mem_be_q    <= ByteEnM;
                    end else if (MemReadM && !hit) begin
                        state_q    <= FETCH;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {AddrM[DATA_WIDTH-1:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (MemAck) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (MemAck) begin
                        state_q   <= WDONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                WDONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemBe    = mem_be_q;

    always_comb begin
        StallM = 1'b0;
        DMRd   = '0;
        case (state_q)
            IDLE: begin
                StallM = MemWriteM || (MemReadM && !hit);
                if (MemReadM && hit) begin
                    DMRd = line_data;
                end
            end
            FETCH:   StallM = 1'b1;
            WRITE:   StallM = 1'b1;
            WDONE:   StallM = 1'b0;
            default: StallM = 1'b0;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        load_hit;
    logic        load_miss;

    assign load_hit  = (state_q == IDLE) && MemReadM && !MemWriteM && hit;
    assign load_miss = (state_q == IDLE) && MemReadM && !MemWriteM && !hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (load_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (load_miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed self-checking bench for dcache_responder (default build).
module tb_dcache_responder;

    logic        clk;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [3:0]  ByteEnM;
    logic [31:0] DMRd;
    logic        StallM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBe;
    logic [31:0] MemRData;
    logic        MemAck;

    int errors = 0;
    int checks = 0;

    dcache_responder dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .ByteEnM    (ByteEnM),
        .DMRd       (DMRd),
        .StallM     (StallM),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemBe      (MemBe),
        .MemRData   (MemRData),
        .MemAck     (MemAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (MemReq !== 1'b1 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (MemReq !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout: MemReq=%b required 1", name, MemReq);
        end
    endtask

    task automatic read_miss(input logic [31:0] addr, input logic [31:0] data,
                             input int ack_wait, input string name);
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; AddrM = addr;
        #1;
        checks++;
        if (StallM !== 1'b1 || MemReq !== 1'b0) begin
            errors++;
            $display("FAIL %s miss_stall: StallM=%b MemReq=%b required 1 0", name, StallM, MemReq);
        end
        wait_req(name);
        checks++;
        if (MemAddr !== {addr[31:2], 2'b00} || MemWe !== 1'b0 || StallM !== 1'b1) begin
            errors++;
            $display("FAIL %s fetch_req: MemAddr=%h MemWe=%b StallM=%b required %h 0 1",
                     name, MemAddr, MemWe, StallM, {addr[31:2], 2'b00});
        end
        repeat (ack_wait - 1) @(negedge clk);
        MemAck = 1'b1; MemRData = data;
        #1;
        checks++;
        if (StallM !== 1'b1 || MemAddr !== {addr[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s ack_cycle: StallM=%b MemAddr=%h required 1 %h",
                     name, StallM, MemAddr, {addr[31:2], 2'b00});
        end
        @(negedge clk);
        MemAck = 1'b0; MemRData = 32'h0;
        #1;
        checks++;
        if (StallM !== 1'b0 || DMRd !== data || MemReq !== 1'b0) begin
            errors++;
            $display("FAIL %s post_fill: StallM=%b DMRd=%h MemReq=%b required 0 %h 0",
                     name, StallM, DMRd, MemReq, data);
        end
    endtask

    task automatic read_hit(input logic [31:0] addr, input logic [31:0] data,
                            input string name);
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; AddrM = addr;
        #1;
        checks++;
        if (StallM !== 1'b0 || DMRd !== data || MemReq !== 1'b0) begin
            errors++;
            $display("FAIL %s hit: StallM=%b DMRd=%h MemReq=%b required 0 %h 0",
                     name, StallM, DMRd, MemReq, data);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic also_read, input string name);
        @(negedge clk);
        MemWriteM = 1'b1; MemReadM = also_read; AddrM = addr;
        WriteDataM = data; ByteEnM = be;
        #1;
        checks++;
        if (StallM !== 1'b1) begin
            errors++;
            $display("FAIL %s store_stall: StallM=%b required 1", name, StallM);
        end
        wait_req(name);
        checks++;
        if (MemWe !== 1'b1 || MemBe !== be || MemWData !== data
            || MemAddr !== {addr[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s write_req: MemWe=%b MemBe=%b MemWData=%h MemAddr=%h required 1 %b %h %h",
                     name, MemWe, MemBe, MemWData, MemAddr, be, data, {addr[31:2], 2'b00});
        end
        @(negedge clk);
        MemAck = 1'b1;
        #1;
        checks++;
        if (StallM !== 1'b1) begin
            errors++;
            $display("FAIL %s write_ack_stall: StallM=%b required 1", name, StallM);
        end
        @(negedge clk);
        MemAck = 1'b0;
        #1;
        checks++;
        if (StallM !== 1'b0 || MemReq !== 1'b0) begin
            errors++;
            $display("FAIL %s wdone: StallM=%b MemReq=%b required 0 0", name, StallM, MemReq);
        end
        @(negedge clk);
        MemWriteM = 1'b0; MemReadM = 1'b0; ByteEnM = 4'h0;
        #1;
        checks++;
        if (StallM !== 1'b0 || MemReq !== 1'b0) begin
            errors++;
            $display("FAIL %s no_reissue: StallM=%b MemReq=%b required 0 0", name, StallM, MemReq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; AddrM = 32'h0;
        WriteDataM = 32'h0; ByteEnM = 4'h0; MemRData = 32'h0; MemAck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (MemReq !== 1'b0 || MemWe !== 1'b0 || StallM !== 1'b0 || DMRd !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: MemReq=%b MemWe=%b StallM=%b DMRd=%h required 0 0 0 0",
                     MemReq, MemWe, StallM, DMRd);
        end
    endtask

    task automatic test_cold_read();
        read_miss(32'h0000_0100, 32'hDEAD_BEEF, 3, "cold_read");
    endtask

    task automatic test_repeat_read();
        read_hit(32'h0000_0100, 32'hDEAD_BEEF, "repeat_read_a");
        read_hit(32'h0000_0102, 32'hDEAD_BEEF, "repeat_read_lowbits");
    endtask

    task automatic test_store_hit();
        store(32'h0000_0100, 32'h0000_00AA, 4'b0001, 1'b0, "store_hit");
        read_hit(32'h0000_0100, 32'hDEAD_BEAA, "store_hit_merged");
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        MemReadM = 1'b0; MemAck = 1'b1; MemRData = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (StallM !== 1'b0 || MemReq !== 1'b0 || DMRd !== 32'h0) begin
            errors++;
            $display("FAIL idle_ack: StallM=%b MemReq=%b DMRd=%h required 0 0 0",
                     StallM, MemReq, DMRd);
        end
        @(negedge clk);
        MemAck = 1'b0; MemRData = 32'h0;
        read_hit(32'h0000_0100, 32'hDEAD_BEAA, "idle_ack_line_intact");
    endtask

    task automatic test_conflict_eviction();
        read_miss(32'h0000_0200, 32'h2222_2222, 1, "evict_0x200");
        read_miss(32'h0000_0100, 32'h1111_1111, 2, "evict_reread_0x100");
        read_hit(32'h0000_0100, 32'h1111_1111, "evict_refilled");
    endtask

    task automatic test_store_miss();
        store(32'h0000_0300, 32'h3333_3333, 4'b1111, 1'b0, "store_miss");
        read_hit(32'h0000_0100, 32'h1111_1111, "store_miss_no_alloc");
        read_miss(32'h0000_0300, 32'h4444_4444, 1, "store_miss_refetch");
    endtask

    task automatic test_write_priority();
        store(32'h0000_0300, 32'h0000_5500, 4'b0010, 1'b1, "write_priority");
        read_hit(32'h0000_0300, 32'h4444_5544, "write_priority_merged");
    endtask

    task automatic test_reset_during_fetch();
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; AddrM = 32'h0000_0104;
        #1;
        wait_req("rst_fetch");
        @(negedge clk);
        rst = 1'b1; MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (MemReq !== 1'b0 || StallM !== 1'b0 || DMRd !== 32'h0) begin
            errors++;
            $display("FAIL rst_fetch_cleared: MemReq=%b StallM=%b DMRd=%h required 0 0 0",
                     MemReq, StallM, DMRd);
        end
        MemAck = 1'b1; MemRData = 32'hBAD1_BAD1;
        @(negedge clk);
        MemAck = 1'b0; MemRData = 32'h0;
        #1;
        checks++;
        if (MemReq !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL rst_fetch_late_ack: MemReq=%b StallM=%b required 0 0", MemReq, StallM);
        end
        read_miss(32'h0000_0300, 32'h5555_5555, 2, "rst_valid_cleared");
        read_miss(32'h0000_0104, 32'h6666_6666, 1, "rst_late_ack_not_filled");
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_repeat_read();
        test_store_hit();
        test_ack_ignored();
        test_conflict_eviction();
        test_store_miss();
        test_write_priority();
        test_reset_during_fetch();
        @(negedge clk);
        MemReadM = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
